pcm_output_buffer: RTL
======================

Name: pcm_output_buffer

Overview:
- Consumer end of the synthesis stage: accepts Q2_30 PCM samples written sequentially by the synthesis filterbank and plays them out at a fixed audio sample rate.
- Converts each sample to 16-bit signed with rounding and saturation, then buffers it in a circular BRAM.
- Applies valid/ready backpressure to the writer; emits one sample per rate tick to the DAC/I2S side.

Parameters:
- TICK_DIV, 2268, clk cycles per output sample (100 MHz / 44.1 kHz, rounded).
- DEPTH, 2048, buffer entries; power of two.
- PRIME_LEVEL, 1152, fill level required before playback starts or resumes (one granule pair).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- flush_in  input  1  synchronous clear: drops the buffer and pipeline, returns to PRIME.
- pcm_in  input  32  signed Q2_30 sample from synthesis.
- pcm_valid_in  input  1  pcm_in valid; accepted when pcm_ready_out=1.
- pcm_ready_out  output  1  buffer can accept a sample this cycle.
- pcm_out  output  16  signed 16-bit sample to DAC.
- pcm_valid_out  output  1  one-cycle strobe when pcm_out updates.
- underflow_out  output  1  sticky: a tick found the buffer empty; cleared by rst or flush_in.
- fill_level_out  output  12  committed entries in buffer, 0..DEPTH.

Behaviour:
- Reset (rst=0, async) and flush_in=1:
  - pointers and count = 0; state = PRIME; tick counter = 0; pipelines cleared.
  - pcm_out=0, pcm_valid_out=0, underflow_out=0.
  - pcm_ready_out=1 once rst is deasserted.
  - flush_in takes priority over all same-cycle events.
- Accept: handshake when pcm_valid_in && pcm_ready_out.
  - Stage C registers the converted sample; write commits to RAM and count++ one cycle later.
  - Input-to-fill_level latency is 2 cycles.
- pcm_ready_out = (count + in_flight) < DEPTH, where in_flight = stage-C occupancy.
  - Never overflows; excess samples are stalled, never dropped.
- Conversion (stage C):
  - x >= 2^30 -> 32767; x < -2^30 -> -32768.
  - Otherwise y = (x + 2^14) >>> 15 (arithmetic shift); clamp y to 32767 when rounding overflows.
- Tick counter runs 0..TICK_DIV-1 in every state; tick fires when the counter reaches TICK_DIV-1.
- PRIME state:
  - Ticks produce no output.
  - Go to PLAY when count >= PRIME_LEVEL.
- PLAY state, on each tick:
  - If count>0: issue a read at rd_ptr, advance rd_ptr, count--.
  - RAM read latency is 2 cycles (registered output), so pcm_out updates and pcm_valid_out pulses exactly 3 cycles after the tick.
  - If count==0: drive pcm_out=0, pulse pcm_valid_out 3 cycles after the tick, set underflow_out, go to PRIME.
- Simultaneous write commit and read issue: count unchanged.
- Pointers are log2(DEPTH) bits with natural wrap; count is held separately (log2(DEPTH)+1 bits).
- No reordering: output order equals accept order.
- Between strobes pcm_out holds its last value.

Decomposition:
- Shared package mp3_pkg:
  - typedef q2_30_t (logic signed [31:0]) and pcm16_t (logic signed [15:0]).
  - constants SAMPLES_PER_GRANULE_PAIR=1152 and SUBBANDS=32.
  - function q2_30_to_pcm16 (the rounding/saturation rule above), so the bench model shares it.
- Sub-module: the existing xilinx_single_port_ram_read_first is unsuitable because simultaneous read and write are required.
  - Instantiate a new simple dual-port BRAM, xilinx_simple_dual_port_ram, with HIGH_PERFORMANCE output register.
  - Parameters: width 16, DEPTH.
- Control: one FSM (PRIME/PLAY) plus the tick counter, in this module.

Test Plan:
- Conversion, with TICK_DIV=8, PRIME_LEVEL=4, write 4 samples, run ticks:
  - inputs 0x40000000, 0x3FFFC000, 0xC0000000, 0x00004000;
  - required pcm_out sequence 32767, 32767, -32768, 1.
- Prime/latency: write 3 samples -> no pcm_valid_out over 40 cycles; 4th accepted -> first strobe exactly 3 cycles after the next tick; subsequent strobes every 8 cycles.
- Backpressure, DEPTH=16: hold pcm_valid_in=1 with no ticks -> exactly 16 accepts; pcm_ready_out=0 with fill_level_out=16. One tick -> ready reasserts, 17th sample accepted, and the output order is preserved.
- Underflow: prime 4 samples, stop writing -> 4 data strobes, then a strobe with pcm_out=0 and underflow_out=1, state PRIME. Write 4 more -> playback resumes; underflow_out stays 1 until flush_in.
- Simultaneity: write continuously at 1 sample per 8 cycles while playing -> fill_level_out stays constant within ±1 over 200 cycles; no underflow.
- Reset mid-operation: assert rst=0 asynchronously between clk edges during PLAY with fill=10 -> outputs zero immediately; after release fill_level_out=0, pcm_ready_out=1, no strobes until re-primed. Repeat with flush_in for the same result.

Source files
------------

// File: rtl/mp3_pkg.sv
// mp3_pkg: types, constants and the Q2_30 -> PCM16 conversion shared by
// the synthesis-side blocks of the MP3 decoder.
package mp3_pkg;

    typedef logic signed [31:0] q2_30_t;
    typedef logic signed [15:0] pcm16_t;

    typedef enum logic {PRIME, PLAY} pcm_buf_state_e;

    localparam int SAMPLES_PER_GRANULE_PAIR = 1152;
    localparam int SUBBANDS                 = 32;

    localparam q2_30_t Q_ONE = 32'sh4000_0000;

    // Round half up to 16 bits. Inputs at or beyond full scale saturate.
    // The top in-range inputs round up to 32768, so that value is clamped as well.
    function automatic pcm16_t q2_30_to_pcm16(input q2_30_t x);
        q2_30_t y;
        y = (x + 32'sd16384) >>> 15;
        return (x >= Q_ONE)     ? 16'sh7FFF :
               (x < -Q_ONE)     ? 16'sh8000 :
               (y > 32'sd32767) ? 16'sh7FFF : y[15:0];
    endfunction

endpackage

// File: rtl/xilinx_simple_dual_port_ram.sv
// xilinx_simple_dual_port_ram: one write port and one read port on a shared clock.
// In HIGH_PERFORMANCE mode the read data passes through an extra output
// register, so read latency is 2 cycles. Otherwise read latency is 1 cycle.
// Ports:
//   clk         - clock
//   we/waddr/wdata - write port
//   re/raddr    - read enable and address
//   rdata       - read data
module xilinx_simple_dual_port_ram #(
    parameter int    WIDTH           = 16,
    parameter int    DEPTH           = 2048,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) ram_q <= mem[raddr];
    end

    if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_hp
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk) dout_q <= ram_q;
        assign rdata = dout_q;
    end else begin : g_lp
        assign rdata = ram_q;
    end
endmodule

// File: rtl/pcm_output_buffer.sv
// pcm_output_buffer: converts Q2_30 samples to 16-bit PCM, buffers them in a
// circular BRAM, and plays one sample out per audio rate tick.
// Ports:
//   clk, rst (async, active-low), flush_in (sync clear)
//   pcm_in/pcm_valid_in/pcm_ready_out - writer handshake (Q2_30 samples)
//   pcm_out/pcm_valid_out             - 16-bit sample and one-cycle strobe to the DAC
//   underflow_out                     - sticky, set when a tick finds the buffer empty
//   fill_level_out                    - number of committed entries
module pcm_output_buffer
    import mp3_pkg::*;
#(
    parameter int TICK_DIV    = 2268,
    parameter int DEPTH       = 2048,
    parameter int PRIME_LEVEL = SAMPLES_PER_GRANULE_PAIR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_in,
    input  logic [31:0] pcm_in,
    input  logic        pcm_valid_in,
    output logic        pcm_ready_out,
    output logic [15:0] pcm_out,
    output logic        pcm_valid_out,
    output logic        underflow_out,
    output logic [11:0] fill_level_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);

    pcm_buf_state_e state_q, state_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           c_valid_q, c_valid_d;
    pcm16_t         c_data_q, c_data_d;
    logic [1:0]     rd_v_q, rd_v_d;
    logic [1:0]     uf_q, uf_d;
    logic [15:0]    pcm_out_q, pcm_out_d;
    logic           pcm_valid_q, pcm_valid_d;
    logic           underflow_q, underflow_d;

    logic        tick, accept, rd_issue, uf_hit;
    logic [15:0] ram_rdata;

    assign tick          = tick_cnt_q == TW'(TICK_DIV - 1);
    // The sample held in stage C already owns a slot, so it counts toward the limit.
    assign pcm_ready_out = ({1'b0, count_q} + (CW+1)'(c_valid_q)) < (CW+1)'(DEPTH);
    assign accept        = pcm_valid_in && pcm_ready_out;
    assign rd_issue      = (state_q == PLAY) && tick && (count_q != '0);
    assign uf_hit        = (state_q == PLAY) && tick && (count_q == '0);

    always_comb begin
        state_d     = state_q;
        if (state_q == PRIME && count_q >= CW'(PRIME_LEVEL)) state_d = PLAY;
        if (uf_hit) state_d = PRIME;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
        wr_ptr_d    = wr_ptr_q + AW'(c_valid_q);
        rd_ptr_d    = rd_ptr_q + AW'(rd_issue);
        count_d     = count_q + CW'(c_valid_q) - CW'(rd_issue);
        c_valid_d   = accept;
        c_data_d    = q2_30_to_pcm16(pcm_in);
        // An underflow slot travels down the same pipe as a read so that its
        // zero sample lands with identical latency.
        rd_v_d      = {rd_v_q[0], rd_issue | uf_hit};
        uf_d        = {uf_q[0], uf_hit};
        pcm_valid_d = rd_v_q[1];
        pcm_out_d   = rd_v_q[1] ? (uf_q[1] ? '0 : ram_rdata) : pcm_out_q;
        underflow_d = underflow_q | uf_hit;
        if (flush_in) begin
            state_d     = PRIME;
            tick_cnt_d  = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            c_valid_d   = 1'b0;
            rd_v_d      = '0;
            uf_d        = '0;
            pcm_valid_d = 1'b0;
            pcm_out_d   = '0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PRIME;
            tick_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            c_valid_q   <= 1'b0;
            c_data_q    <= '0;
            rd_v_q      <= '0;
            uf_q        <= '0;
            pcm_out_q   <= '0;
            pcm_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            c_valid_q   <= c_valid_d;
            c_data_q    <= c_data_d;
            rd_v_q      <= rd_v_d;
            uf_q        <= uf_d;
            pcm_out_q   <= pcm_out_d;
            pcm_valid_q <= pcm_valid_d;
            underflow_q <= underflow_d;
        end
    end

    xilinx_simple_dual_port_ram #(
        .WIDTH(16),
        .DEPTH(DEPTH),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE")
    ) u_ram (
        .clk  (clk),
        .we   (c_valid_q),
        .waddr(wr_ptr_q),
        .wdata(c_data_q),
        .re   (rd_issue),
        .raddr(rd_ptr_q),
        .rdata(ram_rdata)
    );

    assign pcm_out        = pcm_out_q;
    assign pcm_valid_out  = pcm_valid_q;
    assign underflow_out  = underflow_q;
    assign fill_level_out = 12'(count_q);
endmodule
